spi_responder: RTL and testbench
================================

# spi_responder

Slave-side engine for the processor's single-master, multi-slave SPI link to its execution units (ALU, multiplier, shifter). Each unit instantiates one copy on its own `nss` line. The block:
- detects the master's start bit and deserialises the operand/opcode packet;
- hands the packet to the unit's compute core over a valid handshake;
- serialises the core's result back to the master, preceded by a start bit.

`sclk` is the system clock, so everything runs in the `i_clock` domain.

## Interface
Parameters:
- `DATA_WIDTH`, 16, width of each operand and of the result
- `OP_WIDTH`, 3, opcode width
- `PKT_WIDTH`, `2*DATA_WIDTH+OP_WIDTH` (35), derived, not overridable

Ports:
- `i_clock`  in  1  system clock; also the SPI bit clock
- `i_reset`  in  1  reset; one clock; reset is asynchronous and active-high
- `i_nss`  in  1  this slave's select, active-low
- `i_mosi`  in  1  master-to-slave serial data
- `o_miso`  out  1  slave-to-master serial data, registered
- `o_req_valid`  out  1  one-cycle pulse: `o_opa`/`o_opb`/`o_op` are valid
- `o_opa`  out  DATA_WIDTH  operand A (packet bits [34:19])
- `o_opb`  out  DATA_WIDTH  operand B (packet bits [18:3])
- `o_op`  out  OP_WIDTH  opcode (packet bits [2:0])
- `i_res_valid`  in  1  core result valid; sampled only in COMPUTE
- `i_result`  in  DATA_WIDTH  core result
- `o_busy`  out  1  high in every state except IDLE
- `o_abort`  out  1  one-cycle pulse when a frame is cut short by `i_nss` rising

## Operation
The FSM is one-hot with states IDLE, RECV, COMPUTE, RESP_START, SEND.

- **IDLE**
  - `o_miso`=0.
  - If `i_nss`=0 and `i_mosi`=1 at a posedge: clear the bit counter, go to RECV.
  - A high `i_mosi` while `i_nss`=1 is ignored.
- **RECV**
  - Each posedge shifts `i_mosi` into `pkt[cnt]`, LSB first: first sampled bit is `op[0]`, last is `opa[15]`.
  - After `PKT_WIDTH` samples (cnt 0..34): drive `o_opa`/`o_opb`/`o_op` from the packet, pulse `o_req_valid` for exactly one cycle, go to COMPUTE.
- **COMPUTE**
  - Wait for `i_res_valid`=1.
  - On that edge: latch `i_result` into the shift register, go to RESP_START.
  - No timeout.
  - `i_res_valid` seen in any other state is ignored.
  - `o_opa`/`o_opb`/`o_op` hold their values until the next frame's request.
- **RESP_START**
  - `o_miso`=1 for exactly one cycle (start bit), then go to SEND.
- **SEND**
  - `o_miso`=`result[cnt]`, LSB first, for `DATA_WIDTH` cycles (cnt 0..15).
  - Then go to IDLE with `o_miso`=0.
- **Abort**
  - `i_nss` sampled 1 in RECV, COMPUTE, RESP_START or SEND:
    - go to IDLE next cycle and pulse `o_abort`;
    - `o_miso`=0; no `o_req_valid` is issued;
    - a pending core result is discarded.
- **Counter**
  - One counter, wide enough for `PKT_WIDTH`-1, reused by RECV and SEND.
  - Reset to 0 on every state entry; no wrap inside a state.

## Timing
- Reset (async, `i_reset`=1):
  - state IDLE;
  - `o_miso`, `o_req_valid`, `o_busy`, `o_abort` = 0;
  - `o_opa`, `o_opb`, `o_op`, packet register, result register, counter = 0.
- Reset mid-frame returns to IDLE immediately; no request or result survives.
- The start bit is sampled at edge T0. Packet bit k is sampled at edge T0+1+k; bit 34 at T0+35.
- `o_req_valid` is high in the cycle after T0+35; `o_opa`/`o_opb`/`o_op` are valid in that same cycle.
- If `i_res_valid` is sampled high at edge Tr:
  - `o_miso`=1 during cycle Tr..Tr+1;
  - `result[k]` during cycle Tr+1+k;
  - `o_miso` returns to 0 after Tr+17.
- This matches the master: it samples the start bit, then one result bit per cycle starting with the next edge.
- Minimum start-to-`o_req_valid` latency is 36 cycles.
- Minimum end-to-end frame, with a core that answers in the request cycle: 36 + 1 + 17 = 54 cycles.
- A combinational core answering in the `o_req_valid` cycle is legal; COMPUTE is then left at that cycle's edge.
- `i_nss` is sampled at every edge. An abort takes effect at the edge where `i_nss`=1 is first seen.

## Test plan
- **Basic frame:** opa=0x1234, opb=0x00FF, op=3'b010, sent LSB first after a start bit; core returns 0xBEEF after 4 cycles.
  - Required: exactly one `o_req_valid` with those values.
  - Required: `o_miso` shows 1, then 0xBEEF LSB first (1,1,1,1,0,1,1,1,…), then 0.
- **Zero-latency core:** `i_res_valid` tied to `o_req_valid`, result 0x8001.
  - Required: start bit one cycle after the request.
  - Required: bits 1,0,…,0,1 follow; frame is 54 cycles in total.
- **Ignored start:** `i_mosi`=1 with `i_nss`=1 for 10 cycles.
  - Required: stays IDLE; `o_busy`=0; no `o_req_valid`.
- **Abort in RECV:** `i_nss` rises after 20 packet bits.
  - Required: one `o_abort` pulse; no `o_req_valid`.
  - Then a full frame (opa=0xFFFF, opb=0x0001, op=0) decodes exactly.
- **Abort in SEND:** `i_nss` rises after 5 result bits.
  - Required: `o_miso`=0 the next cycle; `o_abort`=1; `o_busy`=0.
- **Async reset:** `i_reset` pulsed in COMPUTE, between edges.
  - Required: all outputs 0 immediately.
  - Required: a late `i_res_valid` is ignored; the next frame works normally.

Source files
------------

// File: rtl/spi_responder.sv
// Slave-side SPI engine for one execution unit: receives an operand/opcode packet,
// hands it to the compute core, and streams the core's result back behind a start bit.
module spi_responder #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned OP_WIDTH   = 3
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_nss,
    input  logic                  i_mosi,
    output logic                  o_miso,
    output logic                  o_req_valid,
    output logic [DATA_WIDTH-1:0] o_opa,
    output logic [DATA_WIDTH-1:0] o_opb,
    output logic [OP_WIDTH-1:0]   o_op,
    input  logic                  i_res_valid,
    input  logic [DATA_WIDTH-1:0] i_result,
    output logic                  o_busy,
    output logic                  o_abort
);

    localparam int unsigned PKT_WIDTH = 2 * DATA_WIDTH + OP_WIDTH;
    localparam int unsigned CNT_WIDTH = $clog2(PKT_WIDTH);

    typedef enum logic [4:0] {
        IDLE       = 5'b00001,
        RECV       = 5'b00010,
        COMPUTE    = 5'b00100,
        RESP_START = 5'b01000,
        SEND       = 5'b10000
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [PKT_WIDTH-1:0]  pkt_q, pkt_d;
    logic [PKT_WIDTH-1:0]  pkt_full;
    logic [DATA_WIDTH-1:0] res_q, res_d;
    logic                  miso_d, req_valid_d, busy_d, abort_d;
    logic [DATA_WIDTH-1:0] opa_d, opb_d;
    logic [OP_WIDTH-1:0]   op_d;

    // Packet as it will look once the bit on the wire this cycle is included.
    assign pkt_full = {i_mosi, pkt_q[PKT_WIDTH-2:0]};

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            pkt_q       <= '0;
            res_q       <= '0;
            o_miso      <= 1'b0;
            o_req_valid <= 1'b0;
            o_opa       <= '0;
            o_opb       <= '0;
            o_op        <= '0;
            o_busy      <= 1'b0;
            o_abort     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pkt_q       <= pkt_d;
            res_q       <= res_d;
            o_miso      <= miso_d;
            o_req_valid <= req_valid_d;
            o_opa       <= opa_d;
            o_opb       <= opb_d;
            o_op        <= op_d;
            o_busy      <= busy_d;
            o_abort     <= abort_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pkt_d       = pkt_q;
        res_d       = res_q;
        miso_d      = 1'b0;
        req_valid_d = 1'b0;
        abort_d     = 1'b0;
        opa_d       = o_opa;
        opb_d       = o_opb;
        op_d        = o_op;

        case (state_q)
            IDLE: begin
                if (!i_nss && i_mosi) begin
                    state_d = RECV;
                    cnt_d   = '0;
                end
            end
            RECV: begin
                pkt_d[cnt_q] = i_mosi;
                if (cnt_q == CNT_WIDTH'(PKT_WIDTH - 1)) begin
                    state_d     = COMPUTE;
                    cnt_d       = '0;
                    req_valid_d = 1'b1;
                    opa_d       = pkt_full[PKT_WIDTH-1 -: DATA_WIDTH];
                    opb_d       = pkt_full[OP_WIDTH +: DATA_WIDTH];
                    op_d        = pkt_full[OP_WIDTH-1:0];
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            COMPUTE: begin
                if (i_res_valid) begin
                    state_d = RESP_START;
                    cnt_d   = '0;
                    res_d   = i_result;
                    miso_d  = 1'b1;
                end
            end
            RESP_START: begin
                // miso is registered, so each state drives the bit for the following cycle.
                state_d = SEND;
                cnt_d   = '0;
                miso_d  = res_q[0];
                res_d   = res_q >> 1;
            end
            SEND: begin
                if (cnt_q == CNT_WIDTH'(DATA_WIDTH - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    miso_d = res_q[0];
                    res_d  = res_q >> 1;
                    cnt_d  = cnt_q + CNT_WIDTH'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // Deselect mid-frame wins over every transition above.
        if (state_q != IDLE && i_nss) begin
            state_d     = IDLE;
            cnt_d       = '0;
            pkt_d       = '0;
            res_d       = '0;
            miso_d      = 1'b0;
            req_valid_d = 1'b0;
            abort_d     = 1'b1;
            opa_d       = o_opa;
            opb_d       = o_opb;
            op_d        = o_op;
        end

        busy_d = (state_d != IDLE);
    end

endmodule

// File: tb/tb_spi_responder.sv
// Self-checking bench for spi_responder: vector table, random frames against a
// bit-queue model of the response, and hand-written abort/reset sequences.
module tb_spi_responder;

    logic        clock;
    logic        reset;
    logic        nss;
    logic        mosi;
    logic        miso;
    logic        req_valid;
    logic [15:0] opa;
    logic [15:0] opb;
    logic [2:0]  op;
    logic        res_valid;
    logic        res_valid_drv;
    logic        tie_res;
    logic [15:0] result;
    logic        busy;
    logic        abort;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int req_cnt = 0;
    int abort_cnt = 0;
    int t0 = 0;

    typedef struct {
        logic [15:0] opa;
        logic [15:0] opb;
        logic [2:0]  op;
        logic [15:0] res;
        int          lat;
        int          exp_len;
    } vec_t;

    vec_t vecs[5];

    assign res_valid = tie_res ? req_valid : res_valid_drv;

    spi_responder dut (
        .i_clock     (clock),
        .i_reset     (reset),
        .i_nss       (nss),
        .i_mosi      (mosi),
        .o_miso      (miso),
        .o_req_valid (req_valid),
        .o_opa       (opa),
        .o_opb       (opb),
        .o_op        (op),
        .i_res_valid (res_valid),
        .i_result    (result),
        .o_busy      (busy),
        .o_abort     (abort)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (req_valid) req_cnt <= req_cnt + 1;
        if (abort) abort_cnt <= abort_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Start bit then the 35 packet bits, LSB (op[0]) first; ends just after the last sample edge.
    task automatic send_bits(input logic [15:0] a, input logic [15:0] b, input logic [2:0] o,
                             input int nbits);
        logic [34:0] pkt;
        pkt  = {a, b, o};
        nss  = 1'b0;
        mosi = 1'b1;
        step();
        t0 = cyc;
        for (int k = 0; k < nbits; k++) begin
            mosi = pkt[k];
            step();
        end
        mosi = 1'b0;
    endtask

    task automatic run_frame(input logic [15:0] a, input logic [15:0] b, input logic [2:0] o,
                             input logic [15:0] r, input int lat, input int exp_len);
        logic exp_q[$];
        int   req0;
        logic e;
        req0    = req_cnt;
        tie_res = (lat == 0);
        result  = r;
        send_bits(a, b, o, 35);
        check("req_valid", 32'(req_valid), 32'd1);
        check("opa", 32'(opa), 32'(a));
        check("opb", 32'(opb), 32'(b));
        check("op", 32'(op), 32'(o));
        check("busy_req", 32'(busy), 32'd1);
        exp_q.push_back(1'b1);
        for (int k = 0; k < 16; k++) exp_q.push_back(r[k]);
        exp_q.push_back(1'b0);
        if (lat == 0) begin
            step();
        end else begin
            for (int i = 0; i < lat; i++) begin
                step();
                if (i == 0) check("req_pulse_len", 32'(req_valid), 32'd0);
                check("miso_compute", 32'(miso), 32'd0);
            end
            res_valid_drv = 1'b1;
            step();
            res_valid_drv = 1'b0;
        end
        if (lat == 0) check("req_pulse_len", 32'(req_valid), 32'd0);
        for (int i = 0; i < 18; i++) begin
            e = exp_q.pop_front();
            check($sformatf("miso[%0d]", i), 32'(miso), 32'(e));
            if (i < 17) step();
        end
        check("busy_end", 32'(busy), 32'd0);
        check("frame_len", 32'(cyc - t0 + 1), 32'(exp_len));
        check("req_count", 32'(req_cnt - req0), 32'd1);
        tie_res = 1'b0;
        nss     = 1'b1;
        step();
    endtask

    initial begin
        vecs[0] = '{16'h1234, 16'h00FF, 3'b010, 16'hBEEF, 4, 58};
        vecs[1] = '{16'hA5A5, 16'h5A5A, 3'b111, 16'h8001, 0, 54};
        vecs[2] = '{16'hFFFF, 16'h0001, 3'b000, 16'h0000, 1, 55};
        vecs[3] = '{16'h0000, 16'h0000, 3'b101, 16'hFFFF, 7, 61};
        vecs[4] = '{16'h8000, 16'hFFFE, 3'b001, 16'h7FFE, 2, 56};

        reset = 1'b1;
        nss = 1'b1;
        mosi = 1'b0;
        res_valid_drv = 1'b0;
        tie_res = 1'b0;
        result = '0;
        #3;
        check("rst_miso", 32'(miso), 32'd0);
        check("rst_req", 32'(req_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_abort", 32'(abort), 32'd0);
        check("rst_ops", 32'({opa, opb, op} != 35'd0), 32'd0);
        #4;
        reset = 1'b0;
        step();

        foreach (vecs[i])
            run_frame(vecs[i].opa, vecs[i].opb, vecs[i].op, vecs[i].res, vecs[i].lat, vecs[i].exp_len);

        // High mosi while deselected must not start a frame.
        begin
            int r0;
            r0 = req_cnt;
            nss  = 1'b1;
            mosi = 1'b1;
            for (int i = 0; i < 10; i++) begin
                step();
                check("ign_busy", 32'(busy), 32'd0);
            end
            mosi = 1'b0;
            step();
            check("ign_req", 32'(req_cnt - r0), 32'd0);
        end

        // Abort after 20 packet bits, then a clean frame.
        begin
            int r0, a0;
            r0 = req_cnt;
            a0 = abort_cnt;
            send_bits(16'h1111, 16'h2222, 3'b011, 20);
            check("recv_busy", 32'(busy), 32'd1);
            nss = 1'b1;
            step();
            check("recv_abort", 32'(abort), 32'd1);
            check("recv_abort_busy", 32'(busy), 32'd0);
            step();
            check("recv_abort_pulse", 32'(abort), 32'd0);
            step();
            check("recv_abort_cnt", 32'(abort_cnt - a0), 32'd1);
            check("recv_no_req", 32'(req_cnt - r0), 32'd0);
            run_frame(16'hFFFF, 16'h0001, 3'b000, 16'h3C5A, 3, 57);
        end

        // Abort after 5 result bits.
        begin
            logic [15:0] r;
            r = 16'hB36D;
            result = r;
            send_bits(16'h0F0F, 16'hF0F0, 3'b100, 35);
            res_valid_drv = 1'b1;
            step();
            res_valid_drv = 1'b0;
            check("send_start", 32'(miso), 32'd1);
            for (int k = 0; k < 5; k++) begin
                step();
                check($sformatf("send_bit%0d", k), 32'(miso), 32'(r[k]));
            end
            nss = 1'b1;
            step();
            check("send_abort_miso", 32'(miso), 32'd0);
            check("send_abort", 32'(abort), 32'd1);
            check("send_abort_busy", 32'(busy), 32'd0);
            step();
            check("send_abort_pulse", 32'(abort), 32'd0);
        end

        // Async reset between edges while waiting in COMPUTE.
        begin
            int r0;
            send_bits(16'h4321, 16'h8765, 3'b110, 35);
            step();
            check("cmp_busy", 32'(busy), 32'd1);
            #2;
            reset = 1'b1;
            #1;
            check("arst_busy", 32'(busy), 32'd0);
            check("arst_miso", 32'(miso), 32'd0);
            check("arst_ops", 32'({opa, opb, op} != 35'd0), 32'd0);
            check("arst_req_abort", 32'({req_valid, abort}), 32'd0);
            #1;
            reset = 1'b0;
            nss = 1'b1;
            r0 = req_cnt;
            result = 16'hFFFF;
            res_valid_drv = 1'b1;
            step();
            res_valid_drv = 1'b0;
            check("late_res_busy", 32'(busy), 32'd0);
            check("late_res_miso", 32'(miso), 32'd0);
            step();
            check("late_res_miso2", 32'(miso), 32'd0);
            check("late_res_req", 32'(req_cnt - r0), 32'd0);
            run_frame(16'h1357, 16'h2468, 3'b011, 16'hCAFE, 2, 56);
        end

        // Random frames against the bit-queue model.
        for (int i = 0; i < 20; i++) begin
            logic [15:0] ra, rb, rr;
            logic [2:0]  ro;
            int          rl;
            ra = 16'($urandom);
            rb = 16'($urandom);
            ro = 3'($urandom);
            rr = 16'($urandom);
            rl = int'($urandom_range(0, 6));
            run_frame(ra, rb, ro, rr, rl, 54 + rl);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
